// File: rtl/joy_db15_pkg.sv
// Shared constants for the DB15 serial joystick link, used by both the
// device-side responder and the host-side reader.
package joy_db15_pkg;

    localparam int FRAME_BITS = 32;
    localparam int WORD_BITS  = FRAME_BITS / 2;

    // Button bit positions within one 16-bit player word (LS FEDCBAUDLR).
    localparam int DB15_R  = 0;
    localparam int DB15_LF = 1;
    localparam int DB15_DN = 2;
    localparam int DB15_UP = 3;
    localparam int DB15_A  = 4;
    localparam int DB15_B  = 5;
    localparam int DB15_C  = 6;
    localparam int DB15_D  = 7;
    localparam int DB15_E  = 8;
    localparam int DB15_F  = 9;
    localparam int DB15_S  = 10;
    localparam int DB15_L  = 11;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOADING  = 2'd1,
        SHIFTING = 2'd2,
        DONE     = 2'd3
    } joy_state_e;

endpackage

// File: rtl/joy_db15_tx_if.sv
// Parallel joystick words, host strobes and serial/status outputs of the
// DB15 responder; master is the side that drives the words and strobes.
interface joy_db15_tx_if;
    import joy_db15_pkg::*;

    logic [WORD_BITS-1:0] joystick1;
    logic [WORD_BITS-1:0] joystick2;
    logic                 joy_clk_in;
    logic                 joy_load_in;
    logic                 joy_data_out;
    logic                 frame_done;
    logic                 link_active;
    logic [5:0]           bit_count;

    modport master (
        output joystick1, joystick2, joy_clk_in, joy_load_in,
        input  joy_data_out, frame_done, link_active, bit_count
    );

    modport slave (
        input  joystick1, joystick2, joy_clk_in, joy_load_in,
        output joy_data_out, frame_done, link_active, bit_count
    );

endinterface

// File: rtl/joy_db15_tx_sync_edge.sv
// N-stage synchroniser with a history flop for single-cycle rise/fall pulses.
// Flops idle high so a released line produces no spurious edge out of reset.
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              hist;

    always_ff @(posedge clk) begin
        if (reset) begin
            chain <= '1;
            hist  <= 1'b1;
        end else begin
            chain <= {chain[STAGES-2:0], d};
            hist  <= chain[STAGES-1];
        end
    end

    assign q    = chain[STAGES-1];
    assign rise = q & ~hist;
    assign fall = ~q & hist;

endmodule

// File: rtl/joy_db15_tx.sv
// Device-side DB15 responder: emulates the 74HC165 chain polled by a host
// through load/clock strobes sampled in the system clock domain.
//
// state    | meaning
// ---------+---------------------------------------------
// IDLE     | no load seen yet, or watchdog expired
// LOADING  | host load held low, sr tracking the inputs
// SHIFTING | load released, fewer than 32 bits shifted
// DONE     | full frame shifted, output released high
module joy_db15_tx
    import joy_db15_pkg::*;
#(
    parameter int          SYNC_STAGES = 2,
    parameter logic [23:0] TIMEOUT     = 24'd4_800_000
) (
    input  logic          clk,
    input  logic          reset,
    joy_db15_tx_if.slave  jif
);

    localparam logic [1:0] S_IDLE     = IDLE;
    localparam logic [1:0] S_LOADING  = LOADING;
    localparam logic [1:0] S_SHIFTING = SHIFTING;
    localparam logic [1:0] S_DONE     = DONE;

    logic                  clk_q;
    logic                  clk_rise;
    logic                  clk_fall_unused;
    logic                  ld_q;
    logic                  ld_rise;
    logic                  ld_fall;
    logic [FRAME_BITS-1:0] sr;
    logic [5:0]            bit_count;
    logic                  frame_done;
    logic [23:0]           wdog;
    logic                  expired;
    logic [1:0]            state;
    logic [1:0]            state_nxt;

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_clk (
        .clk   (clk),
        .reset (reset),
        .d     (jif.joy_clk_in),
        .q     (clk_q),
        .rise  (clk_rise),
        .fall  (clk_fall_unused)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_load (
        .clk   (clk),
        .reset (reset),
        .d     (jif.joy_load_in),
        .q     (ld_q),
        .rise  (ld_rise),
        .fall  (ld_fall)
    );

    assign expired = (wdog == TIMEOUT);

    // Load is level-sensitive and beats a coincident clock edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr         <= '0;
            bit_count  <= '0;
            frame_done <= 1'b0;
            wdog       <= TIMEOUT;
            state      <= S_IDLE;
        end else begin
            frame_done <= 1'b0;
            if (!ld_q) begin
                sr        <= {jif.joystick2, jif.joystick1};
                bit_count <= '0;
            end else if (clk_rise) begin
                sr         <= {1'b0, sr[FRAME_BITS-1:1]};
                frame_done <= (bit_count == 6'(FRAME_BITS - 1));
                if (bit_count != 6'd63)
                    bit_count <= bit_count + 6'd1;
            end
            if (ld_fall)
                wdog <= '0;
            else if (!expired)
                wdog <= wdog + 24'd1;
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!ld_q)
            state_nxt = S_LOADING;
        else if (expired)
            state_nxt = S_IDLE;
        else begin
            case (state)
                S_LOADING:  if (ld_rise) state_nxt = S_SHIFTING;
                S_SHIFTING: if (bit_count >= 6'(FRAME_BITS)) state_nxt = S_DONE;
                default:    state_nxt = state;
            endcase
        end
    end

    assign jif.joy_data_out = ~sr[0];
    assign jif.frame_done   = frame_done;
    assign jif.link_active  = (wdog < TIMEOUT);
    assign jif.bit_count    = bit_count;

endmodule

// File: tb/tb_joy_db15_tx.sv
// Scoreboard bench for joy_db15_tx: the host driver queues hand-computed
// expectations and strobes a sample; the monitor pops and compares.
module tb_joy_db15_tx;

    localparam logic [23:0] TB_TIMEOUT = 24'd500;
    localparam int K_DATA = 0;
    localparam int K_BCNT = 1;
    localparam int K_LINK = 2;
    localparam int K_FD   = 3;

    typedef struct {
        int          kind;
        int          tag;
        logic [31:0] val;
    } exp_t;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        smp   = 1'b0;
    exp_t        sb[$];
    exp_t        e;
    logic [31:0] act;
    int          vectors     = 0;
    int          miscompares = 0;
    int          fd_seen     = 0;

    joy_db15_tx_if jif();

    joy_db15_tx #(.SYNC_STAGES(2), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .jif   (jif)
    );

    always #5 clk = ~clk;

    function automatic string kname(input int k);
        if (k == K_DATA) return "joy_data_out";
        if (k == K_BCNT) return "bit_count";
        if (k == K_LINK) return "link_active";
        return "frame_done_count";
    endfunction

    always @(negedge clk) begin
        if (jif.frame_done === 1'b1) fd_seen++;
        if (smp) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL scoreboard_underflow: sample strobed with no expected entry at %0t", $time);
            end else begin
                e = sb.pop_front();
                case (e.kind)
                    K_DATA:  act = {31'd0, jif.joy_data_out};
                    K_BCNT:  act = {26'd0, jif.bit_count};
                    K_LINK:  act = {31'd0, jif.link_active};
                    default: act = 32'(fd_seen);
                endcase
                if (act !== e.val) begin
                    miscompares++;
                    $display("FAIL %s[%0d]: actual %0h, expected %0h at %0t",
                             kname(e.kind), e.tag, act, e.val, $time);
                end
                if (e.kind == K_FD) fd_seen = 0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input int kind, input logic [31:0] val, input int tag);
        exp_t x;
        x.kind = kind;
        x.tag  = tag;
        x.val  = val;
        sb.push_back(x);
        smp = 1'b1;
        tick(1);
        smp = 1'b0;
    endtask

    task automatic do_load();
        jif.joy_load_in = 1'b0;
        tick(4);
        jif.joy_load_in = 1'b1;
        tick(8);
    endtask

    task automatic clk_pulse();
        jif.joy_clk_in = 1'b1;
        tick(8);
        jif.joy_clk_in = 1'b0;
        tick(8);
    endtask

    // Expected pin is the inverted frame bit, and released (1) past bit 31.
    task automatic shift_frame(input logic [31:0] word, input int nbits,
                               input int chg_bit, input logic [15:0] chg_val);
        expect_out(K_DATA, {31'd0, ~word[0]}, 0);
        expect_out(K_BCNT, 32'd0, 0);
        for (int i = 1; i <= nbits; i++) begin
            if (i == chg_bit) jif.joystick1 = chg_val;
            clk_pulse();
            expect_out(K_DATA, (i < 32) ? {31'd0, ~word[i[4:0]]} : 32'd1, i);
            expect_out(K_BCNT, 32'(i), i);
        end
        expect_out(K_FD, (nbits >= 32) ? 32'd1 : 32'd0, nbits);
    endtask

    initial begin
        #500_000;
        $display("FAIL global_timeout: bench did not finish in time");
        $fatal(1, "time limit");
    end

    initial begin
        jif.joystick1   = 16'h0000;
        jif.joystick2   = 16'h0000;
        jif.joy_clk_in  = 1'b0;
        jif.joy_load_in = 1'b1;
        tick(5);
        reset = 1'b0;
        tick(5);

        // Reset state with load released and clock low.
        expect_out(K_DATA, 32'd1, 0);
        expect_out(K_BCNT, 32'd0, 0);
        expect_out(K_LINK, 32'd0, 0);
        expect_out(K_FD,   32'd0, 0);

        // First and last bits pressed.
        jif.joystick1 = 16'h0001;
        jif.joystick2 = 16'h8000;
        do_load();
        expect_out(K_LINK, 32'd1, 1);
        shift_frame(32'h8000_0001, 32, 0, 16'h0000);

        // Input change mid-frame must not disturb the snapshot.
        jif.joystick1 = 16'h00FF;
        jif.joystick2 = 16'h0000;
        do_load();
        shift_frame(32'h0000_00FF, 32, 5, 16'hFF00);
        do_load();
        shift_frame(32'h0000_FF00, 32, 0, 16'h0000);

        // Load falling and clock rising together: load wins.
        jif.joystick1   = 16'h0005;
        jif.joystick2   = 16'h0000;
        jif.joy_load_in = 1'b0;
        jif.joy_clk_in  = 1'b1;
        tick(4);
        jif.joy_load_in = 1'b1;
        tick(8);
        jif.joy_clk_in  = 1'b0;
        tick(8);
        shift_frame(32'h0000_0005, 32, 0, 16'h0000);

        // Over-clocking: 40 pulses after a single load.
        jif.joystick1 = 16'hA5A5;
        jif.joystick2 = 16'h3C3C;
        do_load();
        shift_frame(32'h3C3C_A5A5, 40, 0, 16'h0000);

        // Reset at bit 10, then a clean full frame.
        jif.joystick1 = 16'h1234;
        jif.joystick2 = 16'hABCD;
        do_load();
        shift_frame(32'hABCD_1234, 10, 0, 16'h0000);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        expect_out(K_DATA, 32'd1, 100);
        expect_out(K_LINK, 32'd0, 100);
        expect_out(K_BCNT, 32'd0, 100);
        do_load();
        shift_frame(32'hABCD_1234, 32, 0, 16'h0000);

        // Periodic polling keeps the link up; it drops TIMEOUT clocks after
        // the counter is cleared by the last synchronised load fall.
        for (int p = 0; p < 3; p++) begin
            jif.joy_load_in = 1'b0;
            tick(4);
            jif.joy_load_in = 1'b1;
            tick(146);
            expect_out(K_LINK, 32'd1, 200 + p);
        end
        jif.joy_load_in = 1'b0;
        tick(4);
        jif.joy_load_in = 1'b1;
        tick(int'(TB_TIMEOUT) - 2);
        expect_out(K_LINK, 32'd1, 300);
        expect_out(K_LINK, 32'd0, 301);
        tick(10);
        expect_out(K_LINK, 32'd0, 302);

        tick(3);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
